// File: rtl/ai_pkg.sv
// Shared definitions for the AI datapath: default element width, the element type,
// and an index-width helper for counters and memory addresses.
package ai_pkg;

  localparam int AI_DATA_WIDTH = 16;

  typedef logic signed [AI_DATA_WIDTH-1:0] fm_elem_t;

  // Bits needed to index 'depth' items; at least one so ports never collapse to zero width.
  function automatic int idx_width(input int depth);
    if (depth > 1) begin
      return $clog2(depth);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/ai_pool_line_buffer.sv
// Single-port synchronous line buffer that holds one horizontal pair-max per window column.
// It reads before it writes, so the read port returns the old contents of the addressed entry.
module ai_pool_line_buffer
  import ai_pkg::*;
#(
  parameter int DATA_WIDTH = AI_DATA_WIDTH,
  parameter int DEPTH      = 4,
  parameter int AW         = idx_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // The contents are not reset: every entry is written in an even row before an odd row reads it.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      if (we) begin
        mem[addr] <= wdata;
      end
    end
  end

endmodule

// File: rtl/ai_pooling_unit.sv
// 2x2 stride-2 signed max-pooling of a raster-order valid-only stream, with a per-layer
// bypass that has the same one-cycle latency. frame_done marks the last element of each frame.
module ai_pooling_unit
  import ai_pkg::*;
#(
  parameter int DATA_WIDTH = AI_DATA_WIDTH,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  pool_en,
  input  logic                  clr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  frame_done
);

  localparam int HALF_W = IMG_W / 2;
  localparam int CW     = idx_width(IMG_W);
  localparam int RW     = idx_width(IMG_H);
  localparam int AW     = idx_width(HALF_W);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  if (IMG_W < 2 || (IMG_W % 2) != 0 || IMG_H < 2 || (IMG_H % 2) != 0) begin : g_bad_geometry
    $error("ai_pooling_unit: IMG_W and IMG_H must be even and >= 2");
  end

  function automatic logic signed [DATA_WIDTH-1:0] smax(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    return (b > a) ? b : a;
  endfunction

  logic [CW-1:0]                col, col_nxt;
  logic [RW-1:0]                row, row_nxt;
  logic signed [DATA_WIDTH-1:0] h_max, h_max_nxt;
  logic signed [DATA_WIDTH-1:0] din, pair, lb_rdata;
  logic                         accept, col_odd, row_odd, at_last;
  logic                         lb_en, lb_we;
  logic [AW-1:0]                lb_addr;
  logic [DATA_WIDTH-1:0]        out_data_nxt;
  logic                         out_valid_nxt, frame_done_nxt;

  assign din     = in_data;
  assign accept  = in_valid & ~clr;
  assign col_odd = col[0];
  assign row_odd = row[0];
  assign at_last = (col == COL_LAST) && (row == ROW_LAST);
  assign pair    = smax(h_max, din);
  assign lb_addr = AW'(col >> 1);

  // Even rows store the pair-max; the odd row prefetches that entry on its even column,
  // so the registered read is ready when the window-completing element arrives.
  always_comb begin
    lb_en = 1'b0;
    lb_we = 1'b0;
    if (accept && pool_en) begin
      lb_en = (row_odd != col_odd);
      lb_we = !row_odd && col_odd;
    end else begin
      lb_en = 1'b0;
      lb_we = 1'b0;
    end
  end

  ai_pool_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (HALF_W),
    .AW         (AW)
  ) u_line_buf (
    .clk   (clk),
    .en    (lb_en),
    .we    (lb_we),
    .addr  (lb_addr),
    .wdata (pair),
    .rdata (lb_rdata)
  );

  // Position counters and horizontal max; counters also run in bypass so frame_done works there.
  always_comb begin
    col_nxt   = col;
    row_nxt   = row;
    h_max_nxt = h_max;
    if (clr) begin
      col_nxt   = '0;
      row_nxt   = '0;
      h_max_nxt = '0;
    end else if (in_valid) begin
      if (col == COL_LAST) begin
        col_nxt = '0;
        if (row == ROW_LAST) begin
          row_nxt = '0;
        end else begin
          row_nxt = row + RW'(1);
        end
      end else begin
        col_nxt = col + CW'(1);
        row_nxt = row;
      end
      if (pool_en && !col_odd) begin
        h_max_nxt = din;
      end else begin
        h_max_nxt = h_max;
      end
    end else begin
      col_nxt   = col;
      row_nxt   = row;
      h_max_nxt = h_max;
    end
  end

  // Output selection: a pooled result only on the window-completing element; data holds otherwise.
  always_comb begin
    out_data_nxt   = out_data;
    out_valid_nxt  = 1'b0;
    frame_done_nxt = 1'b0;
    if (accept) begin
      frame_done_nxt = at_last;
      if (pool_en) begin
        if (row_odd && col_odd) begin
          out_valid_nxt = 1'b1;
          out_data_nxt  = smax(lb_rdata, pair);
        end else begin
          out_valid_nxt = 1'b0;
          out_data_nxt  = out_data;
        end
      end else begin
        out_valid_nxt = 1'b1;
        out_data_nxt  = in_data;
      end
    end else begin
      out_valid_nxt  = 1'b0;
      frame_done_nxt = 1'b0;
      out_data_nxt   = out_data;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      h_max      <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      col        <= col_nxt;
      row        <= row_nxt;
      h_max      <= h_max_nxt;
      out_data   <= out_data_nxt;
      out_valid  <= out_valid_nxt;
      frame_done <= frame_done_nxt;
    end
  end

endmodule

// File: tb/tb_ai_pooling_unit.sv
// Self-checking bench for ai_pooling_unit on a 4x4 frame, checked every cycle against a
// frame-array reference model plus fixed expected pooled sequences.
module tb_ai_pooling_unit;
  import ai_pkg::*;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst, in_valid, pool_en, clr;
  logic [DW-1:0] in_data, out_data;
  logic          out_valid, frame_done;

  ai_pooling_unit #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .pool_en    (pool_en),
    .clr        (clr),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  fm_elem_t      fm [H][W];
  int            pos;
  logic [DW-1:0] exp_data;
  logic          exp_valid, exp_done;
  logic [DW-1:0] log_q[$];
  logic [DW-1:0] exp_q[$];
  int            done_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic fm_elem_t window_max(input int r0, input int c0);
    fm_elem_t m = fm[r0][c0];
    for (int r = r0; r < r0 + 2; r++)
      for (int c = c0; c < c0 + 2; c++)
        if (fm[r][c] > m) m = fm[r][c];
    return m;
  endfunction

  // Reference: place each accepted element in the frame; a window completes at (odd row, odd col).
  task automatic model_step(input logic v, input logic [DW-1:0] d, input logic c);
    int r, cc;
    exp_valid = 1'b0;
    exp_done  = 1'b0;
    if (c) begin
      pos = 0;
    end else if (v) begin
      r = pos / W;
      cc = pos % W;
      fm[r][cc] = d;
      if (pool_en) begin
        if ((r % 2 == 1) && (cc % 2 == 1)) begin
          exp_valid = 1'b1;
          exp_data  = window_max(r - 1, cc - 1);
        end
      end else begin
        exp_valid = 1'b1;
        exp_data  = d;
      end
      exp_done = (pos == W * H - 1);
      pos = (pos + 1) % (W * H);
    end
  endtask

  task automatic step(input logic v, input logic [DW-1:0] d, input logic c);
    in_valid = v;
    in_data  = d;
    clr      = c;
    model_step(v, d, c);
    @(posedge clk);
    #1;
    check("out_valid", out_valid, exp_valid);
    check("frame_done", frame_done, exp_done);
    check("out_data", out_data, exp_data);
    if (out_valid) log_q.push_back(out_data);
    if (frame_done) done_cnt++;
  endtask

  task automatic send_frame(input int base, input int bubble_pct, input bit row_gap, input bit rnd);
    for (int i = 0; i < W * H; i++) begin
      if (row_gap && i > 0 && (i % W) == 0) begin
        step(1'b0, DW'($urandom), 1'b0);
        step(1'b0, DW'($urandom), 1'b0);
      end
      while ($urandom_range(99) < bubble_pct) step(1'b0, DW'($urandom), 1'b0);
      step(1'b1, rnd ? DW'($urandom) : DW'(base + i + 1), 1'b0);
    end
  endtask

  task automatic push_pool4(input int base);
    exp_q.push_back(DW'(base + 6));
    exp_q.push_back(DW'(base + 8));
    exp_q.push_back(DW'(base + 14));
    exp_q.push_back(DW'(base + 16));
  endtask

  task automatic check_log(input string tag, input int exp_done_cnt);
    check({tag, "_count"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) check(tag, log_q[i], exp_q[i]);
    check({tag, "_frames"}, done_cnt, exp_done_cnt);
    log_q.delete();
    exp_q.delete();
    done_cnt = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, DW'($urandom), 1'b0);
  endtask

  initial begin
    logic [DW-1:0] sgn [W*H];
    rst = 1'b1; in_valid = 1'b0; in_data = '0; clr = 1'b0; pool_en = 1'b1;
    pos = 0; exp_data = '0; exp_valid = 1'b0; exp_done = 1'b0; done_cnt = 0;
    #12;
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_valid", out_valid, 32'd0);
    check("rst_frame_done", frame_done, 32'd0);
    rst = 1'b0;

    // Pool basic, contiguous.
    send_frame(0, 0, 1'b0, 1'b0);
    idle(2);
    push_pool4(0);
    check_log("pool_basic", 1);

    // Signed compare windows in the top row of windows.
    sgn = '{16'hFFFD, 16'hFFFF, 16'h8000, 16'h0001,
            16'hFFFE, 16'hFFFC, 16'h7FFF, 16'h0000,
            16'h1234, 16'hF000, 16'h0042, 16'h8001,
            16'h7FFE, 16'h0007, 16'hC000, 16'hFFFF};
    for (int i = 0; i < W * H; i++) step(1'b1, sgn[i], 1'b0);
    idle(1);
    check("sgn_count", log_q.size(), 32'd4);
    if (log_q.size() >= 2) begin
      check("sgn_neg", log_q[0], 32'h0000FFFF);
      check("sgn_ext", log_q[1], 32'h00007FFF);
    end
    log_q.delete();
    done_cnt = 0;

    // Bubbles, including between the rows of every window.
    send_frame(0, 40, 1'b1, 1'b0);
    idle(2);
    push_pool4(0);
    check_log("bubbles", 1);

    // Bypass.
    pool_en = 1'b0;
    send_frame(0, 0, 1'b0, 1'b0);
    idle(1);
    for (int i = 1; i <= W * H; i++) exp_q.push_back(DW'(i));
    check_log("bypass", 1);
    pool_en = 1'b1;

    // Back-to-back frames across the wrap.
    send_frame(0, 0, 1'b0, 1'b0);
    send_frame(100, 0, 1'b0, 1'b0);
    idle(1);
    push_pool4(0);
    push_pool4(100);
    check_log("b2b", 2);

    // Asynchronous reset mid-frame.
    for (int i = 1; i <= 7; i++) step(1'b1, DW'(i), 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_data", out_data, 32'd0);
    check("mid_rst_valid", out_valid, 32'd0);
    check("mid_rst_done", frame_done, 32'd0);
    pos = 0; exp_data = '0; exp_valid = 1'b0; exp_done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    log_q.delete();
    done_cnt = 0;
    send_frame(0, 0, 1'b0, 1'b0);
    idle(1);
    push_pool4(0);
    check_log("after_rst", 1);

    // Soft clear mid-frame, with a valid element in the clear cycle that must be dropped.
    for (int i = 1; i <= 7; i++) step(1'b1, DW'(i), 1'b0);
    step(1'b1, 16'h7777, 1'b1);
    log_q.delete();
    done_cnt = 0;
    send_frame(0, 0, 1'b0, 1'b0);
    idle(1);
    push_pool4(0);
    check_log("after_clr", 1);

    // Random frames in both modes; mode changes only at frame boundaries.
    for (int f = 0; f < 4; f++) begin
      pool_en = 1'($urandom_range(1));
      send_frame(0, 30, 1'b0, 1'b1);
      idle(1);
      check("rand_frames", done_cnt, 32'd1);
      check("rand_count", log_q.size(), pool_en ? 32'd4 : 32'd16);
      log_q.delete();
      done_cnt = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
